dlnp_bank_ctrl: RTL and testbench
=================================

# dlnp_bank_ctrl

Write scheduler and arbiter for a bank of `DEPTH` DLNP-style latch words. Each word is transparent while its gate is low and is preset to all-ones by a high `PRESET`. The block shares the bank between two write requesters and one bulk-preset requester. It drives every gate and preset line from flops and sequences each write as setup, open and hold phases, so the latch data never changes while a gate is open.

## Interface
Parameters:
- `DEPTH`, 8: number of latch words, 2..16.
- `AW`, 4: address width; must satisfy 2^AW >= `DEPTH`.
- `WIDTH`, 8: data bits per word.

Ports:
- `CLK` in 1: rising-edge clock.
- `RESETN` in 1: asynchronous, active-low reset.
- `REQ0`, `REQ1` in 1: write request from port 0 / port 1; held high until the matching ACK.
- `ADDR0`, `ADDR1` in `AW`: write address; stable while REQ is high.
- `DATA0`, `DATA1` in `WIDTH`: write data; stable while REQ is high.
- `ACK0`, `ACK1` out 1: one-cycle write-done pulse.
- `ERR` out 1: one-cycle pulse coincident with an ACK when the address was >= `DEPTH`.
- `PRE_REQ` in 1: bulk preset request; held high until `PRE_ACK`.
- `PRE_ACK` out 1: one-cycle preset-done pulse.
- `LAT_D` out `WIDTH`: shared latch data bus.
- `LAT_G` out `DEPTH`: per-word gate, active low; idle value is all ones.
- `LAT_PRESET` out `DEPTH`: per-word preset, active high.
- `BUSY` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD, PRE1, PRE2.
- All outputs are registered. No output is decoded combinationally from the state.

Arbitration (evaluated in IDLE only):
- `PRE_REQ` has the highest priority.
- Otherwise, if exactly one of `REQ0`/`REQ1` is high, that port wins.
- If both are high, the port opposite to last-granted pointer `LG` wins. `LG` updates at grant.

Write sequence:
- IDLE: on grant, capture ADDR/DATA into internal registers `a`/`d`, then go to SETUP.
- SETUP: `LAT_D` = `d`; `LAT_G` = all ones. Go to OPEN.
- OPEN: `LAT_G[a]` = 0, all other bits = 1; `LAT_D` = `d`. Go to HOLD.
  - If `a` >= `DEPTH`, `LAT_G` stays all ones and the ERR flag is set.
- HOLD: `LAT_G` = all ones; `LAT_D` = `d`; granted ACK = 1; `ERR` = flag. Go to IDLE.
- The requester may drop REQ or change ADDR/DATA from the cycle after ACK.

Preset sequence:
- PRE1: `LAT_PRESET` = all ones; `LAT_G` = all ones. Go to PRE2.
- PRE2: `LAT_PRESET` = all ones; `PRE_ACK` = 1. Go to IDLE.
- `LAT_PRESET` is all zeros in every other state.

Invariants:
- At most one `LAT_G` bit is low in any cycle.
- A `LAT_G` bit is never low while any `LAT_PRESET` bit is high.
- `LAT_D` holds its value from SETUP through HOLD and keeps that value in IDLE until the next SETUP.

Reset:
- `RESETN` low immediately forces state IDLE, `LAT_G` all ones, `LAT_PRESET` all zeros, `LAT_D` zero, all ACKs/`ERR`/`BUSY` zero, and `LG` = 1 (port 0 wins the first contested grant).
- The latch contents are unaffected.
- If reset occurs mid-write, the write may be partial. The requester re-requests after reset.

## Timing
- The grant is sampled at the clock edge in IDLE.
- Write: REQ high at edge n (IDLE) gives SETUP after n, OPEN after n+1, HOLD/ACK after n+2, IDLE after n+3.
  - Gate-low width is exactly 1 cycle.
  - Throughput is one write per 4 cycles.
- Preset: `PRE_REQ` at edge n gives `LAT_PRESET` high for the 2 cycles following n, with `PRE_ACK` in the second cycle.
- `PRE_REQ` arriving during a write waits until IDLE and then preempts any pending REQ.
- A REQ still high in the ACK cycle is not re-granted. IDLE re-samples it in the next cycle, so a held REQ produces a second write.

## Test plan
- Single write: `REQ0`, `ADDR0`=3, `DATA0`=0xA5 -> `LAT_D`=0xA5 in SETUP; `LAT_G`=0xF7 for exactly one cycle (OPEN); `ACK0` one cycle later; `BUSY` high for 3 cycles.
- Contention: `REQ0` and `REQ1` both high from reset -> port 0 served first, then port 1; with both held continuously, grants alternate 0,1,0,1.
- Preset priority: `PRE_REQ`, `REQ0` and `REQ1` all high in IDLE -> `LAT_PRESET`=0xFF for 2 cycles, `PRE_ACK` in the 2nd, then the writes follow; `LAT_G` stays 0xFF throughout preset.
- Out-of-range: `DEPTH`=6, `ADDR1`=7 -> `LAT_G` all ones for the whole sequence; `ACK1` and `ERR` pulse together.
- Reset mid-write: deassert `RESETN` during OPEN -> `LAT_G` returns to all ones without waiting for a clock edge; all outputs at reset values; `LG` reset so port 0 wins the next contest.
- Invariant checker running across random traffic -> never more than one `LAT_G` bit low, never gate low with preset high, and `LAT_D` never changes while any gate is low.

Source files
------------

// File: rtl/dlnp_bank_ctrl.sv
// dlnp_bank_ctrl: write scheduler / arbiter for a bank of DLNP latch words.
// Two write ports and one bulk-preset port share the bank. Every latch gate,
// preset and data line is driven from a flop so the latches only ever see
// glitch-free controls. Each write runs setup -> open -> hold, so the data bus
// is stable for the whole time a gate is open.
//
// Handshake: a requester raises REQx (or PRE_REQ) and keeps it, together with
// its ADDRx/DATAx, stable until it sees the one-cycle ACKx (PRE_ACK) pulse; it
// may drop or change them from the following cycle. Grants are only taken in
// IDLE, so a request still high in the ACK cycle is served again only when IDLE
// re-samples it one cycle later.
module dlnp_bank_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 4,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             REQ0,
  input  logic [AW-1:0]    ADDR0,
  input  logic [WIDTH-1:0] DATA0,
  input  logic             REQ1,
  input  logic [AW-1:0]    ADDR1,
  input  logic [WIDTH-1:0] DATA1,
  output logic             ACK0,
  output logic             ACK1,
  output logic             ERR,
  input  logic             PRE_REQ,
  output logic             PRE_ACK,
  output logic [WIDTH-1:0] LAT_D,
  output logic [DEPTH-1:0] LAT_G,
  output logic [DEPTH-1:0] LAT_PRESET,
  output logic             BUSY,
  output logic [2:0]       STATE
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    PRE1  = 3'd4,
    PRE2  = 3'd5
  } state_t;

  localparam logic [31:0] DEPTH_U = DEPTH;

  state_t           state;
  logic [AW-1:0]    a;         // captured write address
  logic             lg;        // last granted port (1 after reset so port 0 wins first)
  logic             port;      // port owning the write in flight
  logic             err_flag;  // captured address was outside the bank
  logic             in_range;
  logic             grant0;
  logic             grant1;
  logic [DEPTH-1:0] one_hot;

  // Debug view of the FSM state for checkers.
  assign STATE = state;

  // Address decode of the captured address; only consumed in SETUP.
  assign in_range = ({{(32-AW){1'b0}}, a} < DEPTH_U);
  assign one_hot  = {{(DEPTH-1){1'b0}}, 1'b1} << a;

  // Two-port arbitration: a lone requester wins, a tie goes to the port
  // opposite the last grant. Preset priority is applied in the FSM.
  assign grant1 = REQ1 & (~REQ0 | ~lg);
  assign grant0 = REQ0 & ~grant1;

  // Single FSM; every output is loaded with the value it must hold in the
  // state being entered, so no output is decoded from the state. LAT_D doubles
  // as the captured write-data register and is only reloaded at a grant.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= IDLE;
      a          <= '0;
      lg         <= 1'b1;
      port       <= 1'b0;
      err_flag   <= 1'b0;
      LAT_D      <= '0;
      LAT_G      <= '1;
      LAT_PRESET <= '0;
      ACK0       <= 1'b0;
      ACK1       <= 1'b0;
      ERR        <= 1'b0;
      PRE_ACK    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      ACK0    <= 1'b0;
      ACK1    <= 1'b0;
      ERR     <= 1'b0;
      PRE_ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (PRE_REQ) begin
            state      <= PRE1;
            LAT_PRESET <= '1;
            LAT_G      <= '1;
            BUSY       <= 1'b1;
          end else if (grant0 || grant1) begin
            state <= SETUP;
            a     <= grant1 ? ADDR1 : ADDR0;
            LAT_D <= grant1 ? DATA1 : DATA0;
            LAT_G <= '1;
            port  <= grant1;
            lg    <= grant1;
            BUSY  <= 1'b1;
          end
        end
        SETUP: begin
          // Open exactly one gate for one cycle; an out-of-bank address opens none.
          state    <= OPEN;
          LAT_G    <= in_range ? ~one_hot : '1;
          err_flag <= ~in_range;
        end
        OPEN: begin
          state <= HOLD;
          LAT_G <= '1;
          ACK0  <= ~port;
          ACK1  <= port;
          ERR   <= err_flag;
        end
        HOLD: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        PRE1: begin
          state   <= PRE2;
          PRE_ACK <= 1'b1;
        end
        PRE2: begin
          state      <= IDLE;
          LAT_PRESET <= '0;
          BUSY       <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          LAT_G      <= '1;
          LAT_PRESET <= '0;
          BUSY       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlnp_bank_ctrl.sv
// Bench for dlnp_bank_ctrl: directed scenarios followed by random traffic, with
// a transaction-level reference model that expands each grant into its
// expected per-cycle output waveform.
`timescale 1ns/1ps
module tb_dlnp_bank_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 4;
  localparam int WIDTH = 8;

  // ---------------- clock / reset ----------------
  logic CLK    = 1'b0;
  logic RESETN = 1'b1;
  always #5 CLK = ~CLK;

  // ---------------- main DUT (DEPTH 8) ----------------
  logic             REQ0 = 1'b0, REQ1 = 1'b0, PRE_REQ = 1'b0;
  logic [AW-1:0]    ADDR0 = '0, ADDR1 = '0;
  logic [WIDTH-1:0] DATA0 = '0, DATA1 = '0;
  logic             ACK0, ACK1, ERR, PRE_ACK, BUSY;
  logic [WIDTH-1:0] LAT_D;
  logic [DEPTH-1:0] LAT_G, LAT_PRESET;
  logic [2:0]       STATE;

  dlnp_bank_ctrl #(.DEPTH(DEPTH), .AW(AW), .WIDTH(WIDTH)) u_dut (
    .CLK(CLK), .RESETN(RESETN),
    .REQ0(REQ0), .ADDR0(ADDR0), .DATA0(DATA0),
    .REQ1(REQ1), .ADDR1(ADDR1), .DATA1(DATA1),
    .ACK0(ACK0), .ACK1(ACK1), .ERR(ERR),
    .PRE_REQ(PRE_REQ), .PRE_ACK(PRE_ACK),
    .LAT_D(LAT_D), .LAT_G(LAT_G), .LAT_PRESET(LAT_PRESET),
    .BUSY(BUSY), .STATE(STATE)
  );

  // ---------------- second DUT (DEPTH 6) for out-of-range ----------------
  logic             s_req0 = 1'b0, s_req1 = 1'b0, s_pre = 1'b0;
  logic [AW-1:0]    s_addr0 = '0, s_addr1 = '0;
  logic [WIDTH-1:0] s_data0 = '0, s_data1 = '0;
  logic             s_ack0, s_ack1, s_err, s_pre_ack, s_busy;
  logic [WIDTH-1:0] s_lat_d;
  logic [5:0]       s_lat_g, s_lat_pre;
  logic [2:0]       s_state;

  dlnp_bank_ctrl #(.DEPTH(6), .AW(AW), .WIDTH(WIDTH)) u_dut6 (
    .CLK(CLK), .RESETN(RESETN),
    .REQ0(s_req0), .ADDR0(s_addr0), .DATA0(s_data0),
    .REQ1(s_req1), .ADDR1(s_addr1), .DATA1(s_data1),
    .ACK0(s_ack0), .ACK1(s_ack1), .ERR(s_err),
    .PRE_REQ(s_pre), .PRE_ACK(s_pre_ack),
    .LAT_D(s_lat_d), .LAT_G(s_lat_g), .LAT_PRESET(s_lat_pre),
    .BUSY(s_busy), .STATE(s_state)
  );

  // ---------------- check bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] d;
    logic [7:0] g;
    logic [7:0] pre;
    logic       ack0;
    logic       ack1;
    logic       err;
    logic       pre_ack;
    logic       busy;
  } exp_t;

  exp_t       exp_q[$];   // expected outputs for the cycles still to come
  exp_t       cur;        // expected outputs for the current cycle
  int         last_grant = 1;
  logic [7:0] last_d = '0;
  int         win;
  logic [3:0] w_addr;
  logic       w_err;
  logic [7:0] w_gate;

  function automatic exp_t rec(input logic [7:0] d, input logic [7:0] g, input logic [7:0] pre,
                               input logic a0, input logic a1, input logic e,
                               input logic pa, input logic b);
    exp_t r;
    r.d = d; r.g = g; r.pre = pre;
    r.ack0 = a0; r.ack1 = a1; r.err = e; r.pre_ack = pa; r.busy = b;
    return r;
  endfunction

  // A grant expands into the whole expected waveform of the operation,
  // including the trailing cycle in which no new grant can be taken.
  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      exp_q.delete();
      last_grant = 1;
      last_d     = '0;
      cur        = rec(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else if (PRE_REQ) begin
      exp_q.push_back(rec(last_d, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(rec(last_d, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      exp_q.push_back(rec(last_d, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      cur = exp_q.pop_front();
    end else if (REQ0 || REQ1) begin
      win        = (REQ0 && REQ1) ? 1 - last_grant : (REQ1 ? 1 : 0);
      last_grant = win;
      w_addr     = (win == 1) ? ADDR1 : ADDR0;
      last_d     = (win == 1) ? DATA1 : DATA0;
      w_err      = (int'(w_addr) >= DEPTH);
      w_gate     = w_err ? 8'hFF : 8'(255 - (1 << w_addr));
      exp_q.push_back(rec(last_d, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(rec(last_d, w_gate, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(rec(last_d, 8'hFF, 8'h00, win == 0, win == 1, w_err, 1'b0, 1'b1));
      exp_q.push_back(rec(last_d, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      cur = exp_q.pop_front();
    end else begin
      cur = rec(last_d, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  end

  // ---------------- scoreboard / invariant monitor ----------------
  logic [7:0] prev_d = '0;
  logic       prev_gate_low = 1'b0;
  int         rst_count = 0;
  int         rst_seen  = 0;
  logic       mon_ack0 = 1'b0, mon_ack1 = 1'b0, mon_pre_ack = 1'b0;
  int         n_ack0 = 0, n_ack1 = 0;
  int         ack_log[$];

  always @(negedge RESETN) rst_count++;

  always @(negedge CLK) begin
    chk("lat_d", LAT_D, cur.d);
    chk("lat_g", LAT_G, cur.g);
    chk("lat_preset", LAT_PRESET, cur.pre);
    chk("ack0", ACK0, cur.ack0);
    chk("ack1", ACK1, cur.ack1);
    chk("err", ERR, cur.err);
    chk("pre_ack", PRE_ACK, cur.pre_ack);
    chk("busy", BUSY, cur.busy);
    chk("inv_one_gate", $countones(~LAT_G) <= 1, 1);
    chk("inv_gate_preset", (LAT_G == 8'hFF) || (LAT_PRESET == 8'h00), 1);
    if (rst_seen == rst_count && (prev_gate_low || LAT_G != 8'hFF))
      chk("inv_d_stable", LAT_D, prev_d);
    prev_d        = LAT_D;
    prev_gate_low = (LAT_G != 8'hFF);
    rst_seen      = rst_count;
    mon_ack0      = ACK0;
    mon_ack1      = ACK1;
    mon_pre_ack   = PRE_ACK;
    if (ACK0) begin n_ack0++; ack_log.push_back(0); end
    if (ACK1) begin n_ack1++; ack_log.push_back(1); end
  end

  // ---------------- drivers ----------------
  // mode: 0 = drop after ACK, 1 = keep requesting with fresh addr/data,
  //       2 = random requester
  int   mode0 = 0, mode1 = 0;
  logic pre_rand = 1'b0;
  int   n_issue0 = 0, n_issue1 = 0;

  task automatic service();
    if (mon_ack0 && REQ0) begin
      if (mode0 == 1) begin
        ADDR0 = 4'($urandom_range(0, 15)); DATA0 = 8'($urandom); n_issue0++;
      end else REQ0 = 1'b0;
    end else if (!REQ0 && mode0 == 2 && $urandom_range(0, 99) < 30) begin
      REQ0 = 1'b1; ADDR0 = 4'($urandom_range(0, 15)); DATA0 = 8'($urandom); n_issue0++;
    end
    if (mon_ack1 && REQ1) begin
      if (mode1 == 1) begin
        ADDR1 = 4'($urandom_range(0, 15)); DATA1 = 8'($urandom); n_issue1++;
      end else REQ1 = 1'b0;
    end else if (!REQ1 && mode1 == 2 && $urandom_range(0, 99) < 30) begin
      REQ1 = 1'b1; ADDR1 = 4'($urandom_range(0, 15)); DATA1 = 8'($urandom); n_issue1++;
    end
    if (mon_pre_ack && PRE_REQ) PRE_REQ = 1'b0;
    else if (!PRE_REQ && pre_rand && $urandom_range(0, 99) < 4) PRE_REQ = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      service();
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick(1);
      done = !REQ0 && !REQ1 && !PRE_REQ && !BUSY;
    end
    chk(tag, done, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  int exp_order[4] = '{0, 1, 0, 1};
  int base0, base1, iss0, iss1;

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #1 RESETN = 1'b0;
    #1;
    chk("rst_lat_g", LAT_G, 8'hFF);
    chk("rst_lat_preset", LAT_PRESET, 8'h00);
    chk("rst_lat_d", LAT_D, 8'h00);
    chk("rst_busy", BUSY, 0);
    chk("rst_acks", {ACK0, ACK1, ERR, PRE_ACK}, 0);
    chk("rst_state", STATE, 0);
    chk("rst6_lat_g", s_lat_g, 6'h3F);

    // Contention from reset: both held continuously -> 0,1,0,1.
    REQ0 = 1'b1; ADDR0 = 4'd1; DATA0 = 8'h11;
    REQ1 = 1'b1; ADDR1 = 4'd2; DATA1 = 8'h22;
    mode0 = 1; mode1 = 1;
    tick(2);
    RESETN = 1'b1;
    for (int i = 0; i < 40 && ack_log.size() < 4; i++) tick(1);
    chk("contention_count", ack_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("grant_order_%0d", i), (i < ack_log.size()) ? ack_log[i] : 99, exp_order[i]);
    mode0 = 0; mode1 = 0;
    wait_idle(40, "drain_contention");

    // Single write to word 3.
    REQ0 = 1'b1; ADDR0 = 4'd3; DATA0 = 8'hA5;
    tick(1);
    chk("sw_setup_d", LAT_D, 8'hA5);
    chk("sw_setup_g", LAT_G, 8'hFF);
    chk("sw_setup_busy", BUSY, 1);
    tick(1);
    chk("sw_open_g", LAT_G, 8'hF7);
    chk("sw_open_ack", ACK0, 0);
    tick(1);
    chk("sw_hold_g", LAT_G, 8'hFF);
    chk("sw_hold_ack", ACK0, 1);
    chk("sw_hold_err", ERR, 0);
    tick(1);
    chk("sw_idle_busy", BUSY, 0);
    chk("sw_idle_ack", ACK0, 0);
    chk("sw_idle_d", LAT_D, 8'hA5);
    wait_idle(10, "drain_single");

    // Preset beats both pending writes.
    base0 = n_ack0; base1 = n_ack1;
    PRE_REQ = 1'b1;
    REQ0 = 1'b1; ADDR0 = 4'd6; DATA0 = 8'h66;
    REQ1 = 1'b1; ADDR1 = 4'd0; DATA1 = 8'h99;
    tick(1);
    chk("pre1_preset", LAT_PRESET, 8'hFF);
    chk("pre1_g", LAT_G, 8'hFF);
    chk("pre1_ack", PRE_ACK, 0);
    tick(1);
    chk("pre2_preset", LAT_PRESET, 8'hFF);
    chk("pre2_g", LAT_G, 8'hFF);
    chk("pre2_ack", PRE_ACK, 1);
    tick(1);
    chk("pre_done_preset", LAT_PRESET, 8'h00);
    chk("pre_done_busy", BUSY, 0);
    tick(1);
    chk("pre_then_write", BUSY, 1);
    wait_idle(30, "drain_preset");
    chk("pre_writes0", n_ack0 - base0, 1);
    chk("pre_writes1", n_ack1 - base1, 1);

    // Out-of-range write on the 6-word bank, then its last valid word.
    s_req1 = 1'b1; s_addr1 = 4'd7; s_data1 = 8'h3C;
    tick(1);
    chk("oor_setup_g", s_lat_g, 6'h3F);
    chk("oor_setup_d", s_lat_d, 8'h3C);
    tick(1);
    chk("oor_open_g", s_lat_g, 6'h3F);
    tick(1);
    chk("oor_hold_g", s_lat_g, 6'h3F);
    chk("oor_hold_ack1", s_ack1, 1);
    chk("oor_hold_err", s_err, 1);
    chk("oor_hold_ack0", s_ack0, 0);
    tick(1);
    chk("oor_idle_err", s_err, 0);
    s_req1 = 1'b1; s_addr1 = 4'd5; s_data1 = 8'hC3;
    tick(2);
    chk("edge_open_g", s_lat_g, 6'h1F);
    tick(1);
    chk("edge_hold_ack1", s_ack1, 1);
    chk("edge_hold_err", s_err, 0);
    tick(1);
    s_req1 = 1'b0;

    // Reset in the middle of a write.
    REQ0 = 1'b1; ADDR0 = 4'd2; DATA0 = 8'h5A;
    tick(2);
    chk("mid_open_g", LAT_G, 8'hFB);
    #2 RESETN = 1'b0; REQ0 = 1'b0;
    #1;
    chk("mid_rst_g", LAT_G, 8'hFF);
    chk("mid_rst_d", LAT_D, 8'h00);
    chk("mid_rst_preset", LAT_PRESET, 8'h00);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_acks", {ACK0, ACK1, ERR, PRE_ACK}, 0);
    chk("mid_rst_state", STATE, 0);
    tick(1);
    REQ0 = 1'b1; ADDR0 = 4'd4; DATA0 = 8'h44;
    REQ1 = 1'b1; ADDR1 = 4'd5; DATA1 = 8'h55;
    tick(1);
    RESETN = 1'b1;
    tick(1);
    chk("post_rst_d", LAT_D, 8'h44);
    tick(1);
    chk("post_rst_g", LAT_G, 8'hEF);
    tick(1);
    chk("post_rst_ack0", ACK0, 1);
    chk("post_rst_ack1", ACK1, 0);
    wait_idle(30, "drain_post_rst");

    // Random traffic; every request issued must be acknowledged.
    base0 = n_ack0; base1 = n_ack1;
    iss0 = n_issue0; iss1 = n_issue1;
    mode0 = 2; mode1 = 2; pre_rand = 1'b1;
    tick(600);
    mode0 = 0; mode1 = 0; pre_rand = 1'b0;
    wait_idle(60, "drain_random");
    chk("rand_served0", n_ack0 - base0, n_issue0 - iss0);
    chk("rand_served1", n_ack1 - base1, n_issue1 - iss1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
